// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: FSM encoding and register-index width.
// The register file and address decoder use the same index type.
package reg_dump_pkg;

    localparam int REG_IDX_W = 5;
    localparam int MAX_REGS  = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    function automatic reg_idx_t idx_next(input reg_idx_t idx);
        return idx + reg_idx_t'(1);
    endfunction

endpackage

// File: rtl/reg_dump.sv
// Walks register indices 0..NUM_REGS-1 through a combinational register-file read port
// and streams each captured value out over a valid/ready beat interface.
//
// state | meaning
// IDLE  | waiting for Start_i
// READ  | index on Read_Register_o, read data captured at the clock edge
// SEND  | beat presented on Dump_Data_o/Dump_Index_o until accepted
// DONE  | one-cycle Done_o pulse after the last beat
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int N        = 32,
    parameter int NUM_REGS = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Start_i,
    input  logic                 Abort_i,
    output logic [REG_IDX_W-1:0] Read_Register_o,
    input  logic [N-1:0]         Read_Data_i,
    output logic [N-1:0]         Dump_Data_o,
    output logic [REG_IDX_W-1:0] Dump_Index_o,
    output logic                 Dump_Valid_o,
    input  logic                 Dump_Ready_i,
    output logic                 Busy_o,
    output logic                 Done_o
);

    localparam reg_idx_t LAST_IDX = reg_idx_t'(NUM_REGS - 1);

    dump_state_t state, state_nx;
    reg_idx_t    idx, idx_nx;
    logic        capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            Dump_Data_o  <= '0;
            Dump_Index_o <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (capture) begin
                Dump_Data_o  <= Read_Data_i;
                Dump_Index_o <= idx;
            end
        end
    end

    // Abort wins over a handshake in the same cycle; the last beat parks the index.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (Start_i) begin
                    idx_nx   = '0;
                    state_nx = READ;
                end
            end
            READ: begin
                if (Abort_i) begin
                    state_nx = IDLE;
                end else begin
                    capture  = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (Abort_i) begin
                    state_nx = IDLE;
                end else if (Dump_Ready_i) begin
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx_next(idx);
                        state_nx = READ;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Read_Register_o = (state == READ) ? idx : '0;
    assign Dump_Valid_o    = (state == SEND);
    assign Busy_o          = (state != IDLE);
    assign Done_o          = (state == DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a 32-register instance exercised with stalls, abort,
// held start and mid-dump reset, plus a 4-register instance.
module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int N = 32;

    typedef struct packed {
        logic [4:0]   idx;
        logic [N-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-register instance
    logic         start, abort, ready;
    logic [4:0]   rd_reg;
    logic [N-1:0] rd_data;
    logic [N-1:0] dd;
    logic [4:0]   di;
    logic         dv, busy, done;

    // 4-register instance
    logic         s_start, s_abort, s_ready;
    logic [4:0]   s_rd_reg;
    logic [N-1:0] s_rd_data;
    logic [N-1:0] s_dd;
    logic [4:0]   s_di;
    logic         s_dv, s_busy, s_done;

    // register file preload: reg k = 0x1000 + k
    assign rd_data   = 32'h1000 + 32'(rd_reg);
    assign s_rd_data = 32'h1000 + 32'(s_rd_reg);

    reg_dump #(.N(N), .NUM_REGS(32)) u_dut (
        .clk(clk), .reset(reset), .Start_i(start), .Abort_i(abort),
        .Read_Register_o(rd_reg), .Read_Data_i(rd_data),
        .Dump_Data_o(dd), .Dump_Index_o(di), .Dump_Valid_o(dv),
        .Dump_Ready_i(ready), .Busy_o(busy), .Done_o(done)
    );

    reg_dump #(.N(N), .NUM_REGS(4)) u_dut4 (
        .clk(clk), .reset(reset), .Start_i(s_start), .Abort_i(s_abort),
        .Read_Register_o(s_rd_reg), .Read_Data_i(s_rd_data),
        .Dump_Data_o(s_dd), .Dump_Index_o(s_di), .Dump_Valid_o(s_dv),
        .Dump_Ready_i(s_ready), .Busy_o(s_busy), .Done_o(s_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    beat_t exp_q[$];
    beat_t exp_q4[$];
    beat_t e_big, e_small;
    int    n_done = 0, n_done4 = 0, n_beats4 = 0, exp_dones = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (busy && !dv && !done) begin
                check("rd_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rd_addr", rd_reg, exp_q[0].idx);
            end else begin
                check("rd_addr_zero", rd_reg, 0);
            end
            if (dv && ready && !abort) begin
                if (exp_q.size() == 0) check("beat_spurious", exp_q.size(), 1);
                else begin
                    e_big = exp_q.pop_front();
                    check("beat_idx", di, e_big.idx);
                    check("beat_data", dd, e_big.data);
                end
            end
            if (done) n_done++;

            if (s_dv && s_ready) begin
                if (exp_q4.size() == 0) check("beat4_spurious", exp_q4.size(), 1);
                else begin
                    e_small = exp_q4.pop_front();
                    check("beat4_idx", s_di, e_small.idx);
                    check("beat4_data", s_dd, e_small.data);
                    n_beats4++;
                end
            end
            if (s_done) n_done4++;
        end
    end

    task automatic run_dump(input bit pre_started, input bit hold, input int stall_idx,
                            input int abort_idx, input int rst_idx);
        int c0, stalls, done0;
        bit fin;
        if (!pre_started) begin
            @(posedge clk); #1;
            start = 1'b1;
        end
        c0 = cyc;
        for (int k = 0; k < 32; k++)
            exp_q.push_back('{idx: 5'(k), data: 32'(32'h1000 + k)});
        done0  = n_done;
        stalls = 0;
        fin    = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            abort = 1'b0;
            ready = 1'b1;
            if (k == 0) check("first_valid_latency", dv, 0);
            if (k == 1) check("first_valid_at_t2", dv, 1);
            if (done) begin
                check("done_cycle", cyc - c0, 2 * 32 + 1 + stalls);
                check("q_empty_at_done", exp_q.size(), 0);
                exp_dones++;
                fin = 1'b1;
            end else if (dv && int'(di) == abort_idx) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_valid", dv, 0);
                exp_q.delete();
                repeat (70) @(posedge clk);
                #1;
                check("abort_no_done", n_done, done0);
                fin = 1'b1;
            end else if (dv && int'(di) == rst_idx) begin
                reset = 1'b1;
                #1;
                check("rst_rd_reg", rd_reg, 0);
                check("rst_data", dd, 0);
                check("rst_index", di, 0);
                check("rst_valid", dv, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                exp_q.delete();
                @(posedge clk); #1;
                reset = 1'b0;
                check("rst_no_done", n_done, done0);
                fin = 1'b1;
            end else if (dv && int'(di) == stall_idx && stalls < 5) begin
                ready = 1'b0;
                check("stall_idx", di, 7);
                check("stall_data", dd, 32'h1007);
                stalls++;
            end
        end
        check("dump_finished", fin, 1);
    endtask

    initial begin
        int c0;
        bit fin4;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b1;
        s_start = 1'b0;
        s_abort = 1'b0;
        s_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_reg", rd_reg, 0);
        check("reset_data", dd, 0);
        check("reset_index", di, 0);
        check("reset_valid", dv, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_busy4", s_busy, 0);
        reset = 1'b0;

        run_dump(1'b0, 1'b0, -1, -1, -1);
        run_dump(1'b0, 1'b0, 7, -1, -1);
        run_dump(1'b0, 1'b0, -1, 12, -1);
        run_dump(1'b0, 1'b0, -1, -1, -1);

        // Start held through a dump: the IDLE cycle after DONE restarts.
        run_dump(1'b0, 1'b1, -1, -1, -1);
        @(posedge clk); #1;
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
        run_dump(1'b1, 1'b0, -1, -1, -1);

        run_dump(1'b0, 1'b0, -1, -1, 20);
        run_dump(1'b0, 1'b0, -1, -1, -1);

        // 4-register instance
        @(posedge clk); #1;
        s_start = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 4; k++)
            exp_q4.push_back('{idx: 5'(k), data: 32'(32'h1000 + k)});
        fin4 = 1'b0;
        for (int k = 0; k < 50 && !fin4; k++) begin
            @(posedge clk); #1;
            s_start = 1'b0;
            if (s_done) begin
                check("done4_cycle", cyc - c0, 2 * 4 + 1);
                fin4 = 1'b1;
            end
        end
        check("dump4_finished", fin4, 1);
        repeat (5) @(posedge clk);
        #1;
        check("beats4_count", n_beats4, 4);
        check("done4_count", n_done4, 1);
        check("q4_empty", exp_q4.size(), 0);
        check("busy4_idle", s_busy, 0);

        check("done_count", n_done, exp_dones);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
